// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter merging NumInp request ports onto one TCDM bank adapter port.
// Responses come back in request order and are steered home through a port-index FIFO.

module tcdm_bank_arbiter_checker (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic out_resp_valid_i,
    input  logic fifo_empty_i
);
    // An adapter response with nothing outstanding means the adapter broke ordering
    resp_without_req_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(out_resp_valid_i && fifo_empty_i))
        else $error("tcdm_bank_arbiter: adapter response with no outstanding request");
endmodule

module tcdm_bank_arbiter #(
    parameter int unsigned  NumInp         = 4,
    parameter int unsigned  AddrWidth      = 32,
    parameter int unsigned  DataWidth      = 32,
    parameter type          metadata_t     = logic,
    parameter int unsigned  MaxOutstanding = 4,
    localparam int unsigned BeWidth        = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i  [NumInp],
    output logic                 req_ready_o  [NumInp],
    input  logic [AddrWidth-1:0] req_addr_i   [NumInp],
    input  logic [3:0]           req_amo_i    [NumInp],
    input  logic                 req_write_i  [NumInp],
    input  logic [DataWidth-1:0] req_wdata_i  [NumInp],
    input  logic [BeWidth-1:0]   req_be_i     [NumInp],
    input  metadata_t            req_meta_i   [NumInp],
    output logic                 resp_valid_o [NumInp],
    input  logic                 resp_ready_i [NumInp],
    output logic [DataWidth-1:0] resp_rdata_o [NumInp],
    output metadata_t            resp_meta_o  [NumInp],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [3:0]           out_amo_o,
    output logic                 out_write_o,
    output logic [DataWidth-1:0] out_wdata_o,
    output logic [BeWidth-1:0]   out_be_o,
    output metadata_t            out_meta_o,
    input  logic                 out_resp_valid_i,
    output logic                 out_resp_ready_o,
    input  logic [DataWidth-1:0] out_resp_rdata_i,
    input  metadata_t            out_resp_meta_i
);
    localparam int unsigned IdxW = $clog2(NumInp);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % NumInp;
        return sum[IdxW-1:0];
    endfunction

    logic [IdxW-1:0] rr_r;
    logic            lock_r;
    logic [IdxW-1:0] lock_idx_r;
    logic [IdxW-1:0] fifo_mem_r [MaxOutstanding];
    logic [PtrW-1:0] wptr_r;
    logic [PtrW-1:0] rptr_r;
    logic [CntW-1:0] cnt_r;

    logic [IdxW-1:0] winner_s;
    logic            any_valid_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [IdxW-1:0] head_s;
    logic            out_valid_s;
    logic            push_s;
    logic            pop_s;

    // Winner selection: locked port, else first valid port at or after the pointer
    always_comb begin
        winner_s    = rr_r;
        any_valid_s = 1'b0;
        if (lock_r) begin
            winner_s    = lock_idx_r;
            any_valid_s = req_valid_i[lock_idx_r];
        end else begin
            // Walk from the farthest offset down so the nearest valid port is assigned last
            for (int unsigned k = 0; k < NumInp; k++) begin
                winner_s    = req_valid_i[rr_idx(rr_r, NumInp - 1 - k)] ?
                              rr_idx(rr_r, NumInp - 1 - k) : winner_s;
                any_valid_s = any_valid_s | req_valid_i[rr_idx(rr_r, NumInp - 1 - k)];
            end
        end
    end

    assign fifo_full_s  = (cnt_r == CntW'(MaxOutstanding));
    assign fifo_empty_s = (cnt_r == {CntW{1'b0}});
    assign head_s       = fifo_mem_r[rptr_r];
    assign out_valid_s  = rst_ni & any_valid_s & ~fifo_full_s;
    assign push_s       = out_valid_s & out_ready_i;
    assign pop_s        = out_resp_valid_i & out_resp_ready_o;

    assign out_valid_o  = out_valid_s;
    assign out_addr_o   = req_addr_i[winner_s];
    assign out_amo_o    = req_amo_i[winner_s];
    assign out_write_o  = req_write_i[winner_s];
    assign out_wdata_o  = req_wdata_i[winner_s];
    assign out_be_o     = req_be_i[winner_s];
    assign out_meta_o   = req_meta_i[winner_s];

    assign out_resp_ready_o = rst_ni & ~fifo_empty_s & resp_ready_i[head_s];

    // Per-port handshake steering; response payload is broadcast
    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            req_ready_o[i]  = rst_ni & any_valid_s & out_ready_i & ~fifo_full_s &
                              (winner_s == IdxW'(i));
            resp_valid_o[i] = rst_ni & out_resp_valid_i & ~fifo_empty_s &
                              (head_s == IdxW'(i));
            resp_rdata_o[i] = out_resp_rdata_i;
            resp_meta_o[i]  = out_resp_meta_i;
        end
    end

    // Round-robin pointer and stall lock keeping the out payload stable
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_r       <= {IdxW{1'b0}};
            lock_r     <= 1'b0;
            lock_idx_r <= {IdxW{1'b0}};
        end else if (push_s) begin
            rr_r       <= rr_idx(winner_s, 1);
            lock_r     <= 1'b0;
        end else if (out_valid_s) begin
            lock_r     <= 1'b1;
            lock_idx_r <= winner_s;
        end
    end

    // Port-index FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_r <= {PtrW{1'b0}};
            rptr_r <= {PtrW{1'b0}};
            cnt_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PtrW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PtrW'(1);
            end
            cnt_r <= cnt_r + CntW'(push_s) - CntW'(pop_s);
        end
    end

    // Port-index storage; contents are only read while the FIFO is non-empty
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wptr_r] <= winner_s;
        end
    end

    tcdm_bank_arbiter_checker u_checker (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .out_resp_valid_i (out_resp_valid_i),
        .fifo_empty_i     (fifo_empty_s)
    );
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Randomised bench for tcdm_bank_arbiter: a transaction-level reference model checks
// the request side every cycle, a scoreboard queue checks response steering.

module tb_tcdm_bank_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    typedef logic [7:0] meta_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic          req_valid  [N];
    logic          req_ready  [N];
    logic [AW-1:0] req_addr   [N];
    logic [3:0]    req_amo    [N];
    logic          req_write  [N];
    logic [DW-1:0] req_wdata  [N];
    logic [BW-1:0] req_be     [N];
    meta_t         req_meta   [N];
    logic          resp_valid [N];
    logic          resp_ready [N];
    logic [DW-1:0] resp_rdata [N];
    meta_t         resp_meta  [N];
    logic          out_valid, out_ready, out_write;
    logic [AW-1:0] out_addr;
    logic [3:0]    out_amo;
    logic [DW-1:0] out_wdata;
    logic [BW-1:0] out_be;
    meta_t         out_meta;
    logic          out_resp_valid, out_resp_ready;
    logic [DW-1:0] out_resp_rdata;
    meta_t         out_resp_meta;

    tcdm_bank_arbiter #(
        .NumInp(N), .AddrWidth(AW), .DataWidth(DW), .metadata_t(meta_t), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_amo_i(req_amo), .req_write_i(req_write), .req_wdata_i(req_wdata),
        .req_be_i(req_be), .req_meta_i(req_meta),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_meta_o(resp_meta),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
        .out_amo_o(out_amo), .out_write_o(out_write), .out_wdata_o(out_wdata),
        .out_be_o(out_be), .out_meta_o(out_meta),
        .out_resp_valid_i(out_resp_valid), .out_resp_ready_o(out_resp_ready),
        .out_resp_rdata_i(out_resp_rdata), .out_resp_meta_i(out_resp_meta)
    );

    typedef struct { int port; logic [DW-1:0] rdata; meta_t meta; } exp_t;
    typedef struct { logic [DW-1:0] rdata; meta_t meta; int due; } adp_t;

    exp_t exp_q [$];
    adp_t adp_q [$];
    int   idx_m [$];
    int   rr_m, lock_idx_m, cyc;
    bit   lock_m, resp_held;
    bit   accepted [N];
    int   pv [N];
    int   p_ordy, p_rvalid, p_rrdy, lat_min, lat_max;
    bit   fixed_addr;
    int   n_vec, n_err;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // The emulated adapter answers every read with a value derived from its address
    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return 32'hCAFE0000 + ((a - 32'h100) >> 2);
    endfunction

    task automatic set_pv(input int a, input int b, input int c, input int d);
        pv[0] = a; pv[1] = b; pv[2] = c; pv[3] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !accepted[i])) begin
                req_valid[i] = ($urandom_range(99) < pv[i]);
                req_addr[i]  = fixed_addr ? (32'h100 + 32'(4 * i)) : $urandom();
                req_amo[i]   = 4'($urandom());
                req_write[i] = 1'($urandom());
                req_wdata[i] = $urandom();
                req_be[i]    = 4'($urandom());
                req_meta[i]  = 8'($urandom());
            end
            accepted[i]   = 1'b0;
            resp_ready[i] = ($urandom_range(99) < p_rrdy);
        end
        out_ready = ($urandom_range(99) < p_ordy);
        if (adp_q.size() > 0 &&
            (resp_held || (adp_q[0].due <= cyc && $urandom_range(99) < p_rvalid))) begin
            out_resp_valid = 1'b1;
            out_resp_rdata = adp_q[0].rdata;
            out_resp_meta  = adp_q[0].meta;
            resp_held      = 1'b1;
        end else begin
            out_resp_valid = 1'b0;
            out_resp_rdata = $urandom();
            out_resp_meta  = 8'($urandom());
        end
    endtask

    task automatic step();
        int w;
        bit anyv, full, ev, hs, pop;
        logic [N-1:0] rv, erv;
        exp_t e;
        adp_t a;
        for (int i = 0; i < N; i++) rv[i] = req_ready[i];
        if (!rst_ni) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_req_ready", rv, '0);
            rr_m = 0; lock_m = 0; resp_held = 0;
            idx_m.delete(); adp_q.delete(); exp_q.delete();
            for (int i = 0; i < N; i++) accepted[i] = 1'b1;
            return;
        end
        anyv = 0; w = rr_m;
        if (lock_m) begin
            w = lock_idx_m; anyv = req_valid[w];
        end else begin
            for (int k = 0; k < N; k++)
                if (!anyv && req_valid[(rr_m + k) % N]) begin w = (rr_m + k) % N; anyv = 1; end
        end
        full = (idx_m.size() >= MO);
        ev   = anyv && !full;
        chk("out_valid", out_valid, ev);
        if (ev)
            chk("out_payload", {out_addr, out_amo, out_write, out_wdata, out_be, out_meta},
                {req_addr[w], req_amo[w], req_write[w], req_wdata[w], req_be[w], req_meta[w]});
        if (anyv) begin
            for (int i = 0; i < N; i++) erv[i] = (i == w) && out_ready && !full;
            chk("req_ready", rv, erv);
        end
        hs  = ev && out_ready;
        pop = out_resp_valid && idx_m.size() > 0 && resp_ready[idx_m[0]];
        if (pop) begin
            void'(idx_m.pop_front()); void'(adp_q.pop_front()); resp_held = 0;
        end
        if (hs) begin
            idx_m.push_back(w);
            e.port = w; e.rdata = rdata_of(req_addr[w]); e.meta = req_meta[w];
            exp_q.push_back(e);
            a.rdata = e.rdata; a.meta = e.meta; a.due = cyc + int'($urandom_range(lat_max, lat_min));
            adp_q.push_back(a);
            rr_m = (w + 1) % N; lock_m = 0; accepted[w] = 1'b1;
        end else if (ev) begin
            lock_m = 1; lock_idx_m = w;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            drive();
            @(negedge clk_i);
            step();
            cyc++;
            @(posedge clk_i); #1;
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response is delivered
    initial begin
        logic [N-1:0] rv, erv;
        int p;
        forever begin
            @(negedge clk_i); #1;
            for (int i = 0; i < N; i++) rv[i] = resp_valid[i];
            if (!rst_ni) begin
                chk("rst_resp_valid", rv, '0);
                chk("rst_out_resp_ready", out_resp_ready, 1'b0);
            end else if (out_resp_valid && exp_q.size() > 0) begin
                p = exp_q[0].port;
                for (int i = 0; i < N; i++) erv[i] = (i == p);
                chk("resp_steer", rv, erv);
                chk("out_resp_ready", out_resp_ready, resp_ready[p]);
                if (resp_ready[p]) begin
                    chk("resp_rdata", resp_rdata[p], exp_q[0].rdata);
                    chk("resp_meta", resp_meta[p], exp_q[0].meta);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("resp_idle", rv, '0);
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; rr_m = 0; lock_m = 0; lock_idx_m = 0; resp_held = 0;
        rst_ni = 1'b0; out_ready = 1'b0; out_resp_valid = 1'b0;
        out_resp_rdata = '0; out_resp_meta = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; req_amo[i] = '0; req_write[i] = 1'b0;
            req_wdata[i] = '0; req_be[i] = '0; req_meta[i] = '0; resp_ready[i] = 1'b0;
            accepted[i] = 1'b1;
        end
        set_pv(50, 50, 50, 50);
        p_ordy = 50; p_rvalid = 50; p_rrdy = 50; lat_min = 1; lat_max = 1; fixed_addr = 0;
        @(posedge clk_i); #1;
        run(3);
        rst_ni = 1'b1;

        // fairness: all valid, adapter latency 1, grants 0,1,2,3,0,...
        set_pv(100, 100, 100, 100); fixed_addr = 1;
        p_ordy = 100; p_rvalid = 100; p_rrdy = 100;
        run(8);
        set_pv(0, 0, 0, 0); run(6);

        // lock: port1 stalled, port0 arrives mid-stall
        set_pv(0, 100, 0, 0); p_ordy = 0; run(1);
        set_pv(100, 0, 0, 0); run(2);
        p_ordy = 100; run(2);
        set_pv(0, 0, 0, 0); run(6);

        // FIFO full with responses withheld, then released
        fixed_addr = 0; set_pv(100, 100, 100, 100); p_rvalid = 0; run(6);
        p_rvalid = 100; run(4);
        set_pv(0, 0, 0, 0); run(10);

        // response backpressure at the head port
        set_pv(0, 0, 100, 0); p_rrdy = 0; run(1);
        set_pv(0, 0, 0, 0); run(3);
        p_rrdy = 100; run(4);

        // random traffic, moderate then heavy with variable adapter latency
        set_pv(60, 60, 60, 60); p_ordy = 70; p_rvalid = 60; p_rrdy = 70; lat_min = 1; lat_max = 4;
        run(3000);
        set_pv(90, 90, 90, 90); p_ordy = 85; p_rvalid = 30; p_rrdy = 60;
        run(1000);
        set_pv(0, 0, 0, 0); p_ordy = 100; p_rvalid = 100; p_rrdy = 100; run(30);

        // reset with three outstanding requests and a response on the wire
        lat_min = 1; lat_max = 1;
        set_pv(100, 100, 100, 100); p_rvalid = 0; run(3);
        p_rvalid = 100; rst_ni = 1'b0; run(2);
        set_pv(0, 0, 0, 100); rst_ni = 1'b1; run(1);
        set_pv(0, 0, 0, 0); run(10);

        chk("drain_empty", 128'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
